// File: rtl/tank_motion_ctrl_pkg.sv
// Shared types and constants for the tank motion/fire controller.
// Key defaults match a W/A/S/D/Space player and an arrows/Enter player.
package tank_motion_ctrl_pkg;

    typedef enum logic [2:0] {
        DIR_N,
        DIR_NE,
        DIR_E,
        DIR_SE,
        DIR_S,
        DIR_SW,
        DIR_W,
        DIR_NW
    } dir_t;

    typedef struct packed {
        logic [7:0] up;
        logic [7:0] left;
        logic [7:0] down;
        logic [7:0] right;
        logic [7:0] fire;
    } key_map_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } fsm_t;

    localparam logic [7:0] KEY_NONE = 8'h00;

    localparam key_map_t KEYS_TANK0 = '{
        up: 8'h1A, left: 8'h04, down: 8'h16,
        right: 8'h07, fire: 8'h2C
    };

    localparam key_map_t KEYS_TANK1 = '{
        up: 8'h52, left: 8'h50, down: 8'h51,
        right: 8'h4F, fire: 8'h28
    };

    function automatic logic key_hit(
        input logic [7:0]  code,
        input logic [31:0] kc
    );
        return (code != KEY_NONE) &&
               ((code == kc[7:0])   ||
                (code == kc[15:8])  ||
                (code == kc[23:16]) ||
                (code == kc[31:24]));
    endfunction

    function automatic int start_x(
        input int i,
        input int n,
        input int lo,
        input int hi
    );
        return lo + (i + 1) * (hi - lo) / (n + 1);
    endfunction

endpackage

// File: rtl/tank_motion_ctrl_if.sv
// Keycode/key-map inputs and per-tank state outputs of the controller.
// The controller is the slave; the keycode source and renderers are the master.
interface tank_motion_ctrl_if #(
    parameter int N_TANKS = 2,
    parameter int COORD_W = 10
);
    logic [31:0]            keycode;
    logic [N_TANKS*40-1:0]  key_map;
    logic [N_TANKS*COORD_W-1:0] tank_x;
    logic [N_TANKS*COORD_W-1:0] tank_y;
    logic [N_TANKS*3-1:0]   tank_dir;
    logic [N_TANKS-1:0]     fire_pulse;
    logic                   frame_done;

    modport master (
        output keycode,
        output key_map,
        input  tank_x,
        input  tank_y,
        input  tank_dir,
        input  fire_pulse,
        input  frame_done
    );

    modport slave (
        input  keycode,
        input  key_map,
        output tank_x,
        output tank_y,
        output tank_dir,
        output fire_pulse,
        output frame_done
    );
endinterface

// File: rtl/tank_motion_ctrl_step.sv
// One-tank datapath: key decode, heading, clamped move and fire cooldown.
// Purely combinational; the controller time-shares it across tanks.
module tank_step
    import tank_motion_ctrl_pkg::*;
#(
    parameter int COORD_W       = 10,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 479,
    parameter int TANK_HALF     = 4,
    parameter int STEP          = 1,
    parameter int FIRE_COOLDOWN = 30
) (
    input  logic [31:0]        kc,
    input  key_map_t           keys,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  dir_t               dir,
    input  logic [7:0]         cd,
    output logic [COORD_W-1:0] x_n,
    output logic [COORD_W-1:0] y_n,
    output dir_t               dir_n,
    output logic [7:0]         cd_n,
    output logic               fire
);

    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] XLO = SW'(X_MIN + TANK_HALF);
    localparam logic signed [SW-1:0] XHI = SW'(X_MAX - TANK_HALF);
    localparam logic signed [SW-1:0] YLO = SW'(Y_MIN + TANK_HALF);
    localparam logic signed [SW-1:0] YHI = SW'(Y_MAX - TANK_HALF);
    localparam logic signed [SW-1:0] STEP_S = SW'(STEP);

    function automatic logic [COORD_W-1:0] clamp(
        input logic signed [SW-1:0] v,
        input logic signed [SW-1:0] lo,
        input logic signed [SW-1:0] hi
    );
        logic signed [SW-1:0] r;
        r = v;
        if (v < lo) r = lo;
        else if (v > hi) r = hi;
        return r[COORD_W-1:0];
    endfunction

    logic k_up, k_lf, k_dn, k_rt, k_fire;
    logic mv_n, mv_s, mv_e, mv_w;
    logic signed [SW-1:0] dx, dy, sx, sy;

    assign k_up   = key_hit(keys.up, kc);
    assign k_lf   = key_hit(keys.left, kc);
    assign k_dn   = key_hit(keys.down, kc);
    assign k_rt   = key_hit(keys.right, kc);
    assign k_fire = key_hit(keys.fire, kc);

    // Opposing keys cancel on their axis.
    assign mv_n = k_up & ~k_dn;
    assign mv_s = k_dn & ~k_up;
    assign mv_e = k_rt & ~k_lf;
    assign mv_w = k_lf & ~k_rt;

    always_comb begin
        dx = '0;
        dy = '0;
        if (mv_e) dx = STEP_S;
        else if (mv_w) dx = -STEP_S;
        if (mv_s) dy = STEP_S;
        else if (mv_n) dy = -STEP_S;
        sx = $signed({2'b00, x}) + dx;
        sy = $signed({2'b00, y}) + dy;
        x_n = clamp(sx, XLO, XHI);
        y_n = clamp(sy, YLO, YHI);
    end

    always_comb begin
        dir_n = dir;
        unique case (1'b1)
            mv_n & ~mv_e & ~mv_w: dir_n = DIR_N;
            mv_n & mv_e:          dir_n = DIR_NE;
            mv_e & ~mv_n & ~mv_s: dir_n = DIR_E;
            mv_s & mv_e:          dir_n = DIR_SE;
            mv_s & ~mv_e & ~mv_w: dir_n = DIR_S;
            mv_s & mv_w:          dir_n = DIR_SW;
            mv_w & ~mv_n & ~mv_s: dir_n = DIR_W;
            mv_n & mv_w:          dir_n = DIR_NW;
            default:              dir_n = dir;
        endcase
    end

    always_comb begin
        fire = k_fire && (cd == 8'd0);
        cd_n = cd;
        if (fire) cd_n = 8'(FIRE_COOLDOWN);
        else if (cd != 8'd0) cd_n = cd - 8'd1;
    end

endmodule

// File: rtl/tank_motion_ctrl.sv
// N-tank motion/fire controller on the frame tick.
// A serial IDLE/SCAN/DONE walk feeds one tank_step per cycle.
module tank_motion_ctrl
    import tank_motion_ctrl_pkg::*;
#(
    parameter int N_TANKS       = 2,
    parameter int COORD_W       = 10,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 479,
    parameter int TANK_HALF     = 4,
    parameter int STEP          = 1,
    parameter int FIRE_COOLDOWN = 30
) (
    input logic Clk,
    input logic Reset_n,
    input logic frame_clk,
    tank_motion_ctrl_if.slave bus
);

    localparam int IDX_W = (N_TANKS > 1) ? $clog2(N_TANKS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TANKS - 1);
    localparam logic [COORD_W-1:0] Y_START = COORD_W'((Y_MIN + Y_MAX) / 2);

    logic sync1_q, sync2_q, edge_q, tick;
    fsm_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic pend_q, pend_d;
    logic [31:0] kc_q, kc_d;
    logic [COORD_W-1:0] x_q [N_TANKS];
    logic [COORD_W-1:0] x_d [N_TANKS];
    logic [COORD_W-1:0] y_q [N_TANKS];
    logic [COORD_W-1:0] y_d [N_TANKS];
    dir_t dir_q [N_TANKS];
    dir_t dir_d [N_TANKS];
    logic [7:0] cd_q [N_TANKS];
    logic [7:0] cd_d [N_TANKS];
    logic [N_TANKS-1:0] fire_q, fire_d;
    logic done_q, done_d;

    key_map_t keys [N_TANKS];
    logic [COORD_W-1:0] st_x, st_y;
    dir_t st_dir;
    logic [7:0] st_cd;
    logic st_fire;

    assign tick = sync2_q & ~edge_q;

    for (genvar i = 0; i < N_TANKS; i++) begin : g_tank
        assign keys[i] = bus.key_map[i*40 +: 40];
        assign bus.tank_x[i*COORD_W +: COORD_W] = x_q[i];
        assign bus.tank_y[i*COORD_W +: COORD_W] = y_q[i];
        assign bus.tank_dir[i*3 +: 3] = dir_q[i];
    end

    assign bus.fire_pulse = fire_q;
    assign bus.frame_done = done_q;

    tank_step #(
        .COORD_W       (COORD_W),
        .X_MIN         (X_MIN),
        .X_MAX         (X_MAX),
        .Y_MIN         (Y_MIN),
        .Y_MAX         (Y_MAX),
        .TANK_HALF     (TANK_HALF),
        .STEP          (STEP),
        .FIRE_COOLDOWN (FIRE_COOLDOWN)
    ) u_step (
        .kc    (kc_q),
        .keys  (keys[idx_q]),
        .x     (x_q[idx_q]),
        .y     (y_q[idx_q]),
        .dir   (dir_q[idx_q]),
        .cd    (cd_q[idx_q]),
        .x_n   (st_x),
        .y_n   (st_y),
        .dir_n (st_dir),
        .cd_n  (st_cd),
        .fire  (st_fire)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        kc_d    = kc_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        cd_d    = cd_q;
        fire_d  = '0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick || pend_q) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    kc_d    = bus.keycode;
                end
            end
            SCAN: begin
                if (tick) pend_d = 1'b1;
                x_d[idx_q]    = st_x;
                y_d[idx_q]    = st_y;
                dir_d[idx_q]  = st_dir;
                cd_d[idx_q]   = st_cd;
                fire_d[idx_q] = st_fire;
                if (idx_q == IDX_LAST) state_d = DONE;
                else idx_d = idx_q + 1'b1;
            end
            DONE: begin
                if (tick) pend_d = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset discards any half-finished frame along with all tank state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            kc_q    <= '0;
            fire_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < N_TANKS; i++) begin
                x_q[i]   <= COORD_W'(start_x(i, N_TANKS, X_MIN, X_MAX));
                y_q[i]   <= Y_START;
                dir_q[i] <= DIR_N;
                cd_q[i]  <= 8'd0;
            end
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            kc_q    <= kc_d;
            fire_q  <= fire_d;
            done_q  <= done_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            cd_q    <= cd_d;
        end
    end

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Directed bench for tank_motion_ctrl: a 2-tank unit for most scenarios
// and a 4-tank unit for the pending/drop window.
module tb_tank_motion_ctrl;
    import tank_motion_ctrl_pkg::*;

    localparam int W = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_clk = 1'b0;
    logic [31:0] keycode = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt, fd_lat, fire0, fire1, bfd_cnt;

    always #5 clk = ~clk;

    tank_motion_ctrl_if #(.N_TANKS(2), .COORD_W(W)) a_if ();
    tank_motion_ctrl_if #(.N_TANKS(4), .COORD_W(W)) b_if ();

    assign a_if.keycode = keycode;
    assign b_if.keycode = keycode;
    assign a_if.key_map = {KEYS_TANK1, KEYS_TANK0};
    assign b_if.key_map = {80'h0, KEYS_TANK1, KEYS_TANK0};

    tank_motion_ctrl #(.N_TANKS(2), .COORD_W(W)) u_a (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .frame_clk (frame_clk),
        .bus       (a_if.slave)
    );

    tank_motion_ctrl #(.N_TANKS(4), .COORD_W(W)) u_b (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .frame_clk (frame_clk),
        .bus       (b_if.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int ax(input int i);
        return int'(a_if.tank_x[i*W +: W]);
    endfunction
    function automatic int ay(input int i);
        return int'(a_if.tank_y[i*W +: W]);
    endfunction
    function automatic int ad(input int i);
        return int'(a_if.tank_dir[i*3 +: 3]);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_clk = 1'b0;
        keycode = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One frame: frame_clk high 10 cycles, low 10; fd_lat in cycles from rise.
    task automatic frame();
        fd_cnt = 0; fd_lat = -1; fire0 = 0; fire1 = 0; bfd_cnt = 0;
        @(negedge clk);
        frame_clk = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (a_if.frame_done) begin
                fd_cnt++;
                if (fd_lat < 0) fd_lat = j;
            end
            fire0 += int'(a_if.fire_pulse[0]);
            fire1 += int'(a_if.fire_pulse[1]);
            if (b_if.frame_done) bfd_cnt++;
            if (j == 10) frame_clk = 1'b0;
        end
    endtask

    task automatic frames(input int n, output int shots);
        shots = 0;
        for (int f = 0; f < n; f++) begin
            frame();
            shots += fire0 + fire1;
        end
    endtask

    // Drive frame_clk from pat, one bit per cycle, counting frame_done strobes.
    task automatic pulses(input logic [7:0] pat);
        fd_cnt = 0; bfd_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (a_if.frame_done) fd_cnt++;
            if (b_if.frame_done) bfd_cnt++;
            frame_clk = (j < 8) ? pat[j] : 1'b0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int shots, fe;
        int ff[$];

        do_reset();
        chk("rst_x0", ax(0), 213);
        chk("rst_x1", ax(1), 426);
        chk("rst_y0", ay(0), 239);
        chk("rst_y1", ay(1), 239);
        chk("rst_dir", a_if.tank_dir, 0);
        chk("rst_fire", a_if.fire_pulse, 0);
        chk("rst_done", a_if.frame_done, 0);
        chk("rst_b_x0", b_if.tank_x[W-1:0], 127);

        frames(10, shots);
        chk("idle_shots", shots, 0);
        chk("idle_x0", ax(0), 213);
        chk("idle_dir", a_if.tank_dir, 0);

        keycode = 32'h0000_0007;
        for (int f = 0; f < 5; f++) begin
            frame();
            chk("right_done_lat", fd_lat, 6);
            chk("right_done_cnt", fd_cnt, 1);
        end
        chk("right_x0", ax(0), 218);
        chk("right_dir0", ad(0), 2);
        chk("right_x1", ax(1), 426);
        chk("right_y0", ay(0), 239);

        keycode = 32'h0000_0050;
        frames(500, shots);
        chk("left_clamp_x1", ax(1), 4);
        chk("left_dir1", ad(1), 6);
        chk("left_y1", ay(1), 239);
        chk("left_x0", ax(0), 218);

        keycode = 32'h0050_1A07;
        frame();
        chk("ne_x0", ax(0), 219);
        chk("ne_y0", ay(0), 238);
        chk("ne_dir0", ad(0), 1);
        chk("ne_x1", ax(1), 4);

        keycode = 32'h0000_514F;
        frames(640, shots);
        chk("se_clamp_x1", ax(1), 635);
        chk("se_clamp_y1", ay(1), 475);
        chk("se_dir1", ad(1), 3);
        chk("se_x0", ax(0), 219);

        keycode = 32'h0000_002C;
        for (int f = 0; f < 70; f++) begin
            frame();
            if (fire0 != 0) ff.push_back(f);
            chk("fire_pulse_len", (fire0 > 1) ? 1 : 0, 0);
        end
        chk("fire_shots", ff.size(), 3);
        fe = (ff.size() > 0) ? ff[0] : -1;
        chk("fire_f0", fe, 0);
        fe = (ff.size() > 1) ? ff[1] : -1;
        chk("fire_f1", fe, 31);
        fe = (ff.size() > 2) ? ff[2] : -1;
        chk("fire_f2", fe, 62);
        chk("fire_still_x0", ax(0), 219);

        keycode = '0;
        frames(30, shots);
        keycode = 32'h0000_002C;
        frame();
        chk("repress_f0", fire0, 1);
        keycode = '0;
        frames(9, shots);
        keycode = 32'h0000_002C;
        frame();
        chk("repress_f10", fire0, 0);

        do_reset();
        keycode = 32'h0000_0007;
        pulses(8'b0000_0101);
        chk("pend_runs", fd_cnt, 2);
        chk("pend_x0", ax(0), 215);
        do_reset();
        keycode = 32'h0000_0007;
        pulses(8'b0001_0101);
        chk("drop_runs_b", bfd_cnt, 2);
        chk("drop_x0_b", b_if.tank_x[W-1:0], 129);

        do_reset();
        keycode = 32'h0000_0007;
        @(negedge clk);
        frame_clk = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_x0", ax(0), 214);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_x0", ax(0), 213);
        chk("arst_x1", ax(1), 426);
        chk("arst_dir", a_if.tank_dir, 0);
        chk("arst_done", a_if.frame_done, 0);
        frame_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        frame();
        chk("resume_x0", ax(0), 214);
        chk("resume_done", fd_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
